router_out_reader: RTL and testbench
====================================

# router_out_reader

Consumer for one router output port. It drains packets from an output FIFO using the `vld_out`/`read_enb` handshake and issues its first read well inside the 30-cycle soft-reset window. It re-frames each packet as a byte stream with `pkt_sop`/`pkt_eop`, checks the trailing parity byte and reports good, bad and aborted packets. One instance sits behind each of the router's three output ports, in the bench and in the downstream sink logic.

## Interface
- `START_DELAY`, default 2: cycles spent in WAIT after `vld_out` is seen before the header read. Legal range 0..20.
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `vld_out` in 1: port FIFO non-empty.
- `data_out` in 8: FIFO read data, valid the cycle after `read_enb`.
- `soft_rst` in 1: port soft-reset (FIFO flushed).
- `stall` in 1: downstream back-pressure.
- `read_enb` out 1: FIFO read strobe (combinational).
- `pkt_data` out 8: registered byte stream.
- `pkt_data_vld` out 1: `pkt_data` qualifier.
- `pkt_sop` out 1: marks the header byte.
- `pkt_eop` out 1: marks the parity byte.
- `pkt_len` out 6: latched header length field.
- `pkt_addr` out 2: latched header address field.
- `pkt_done` out 1: one-cycle pulse, packet complete.
- `pkt_err` out 1: one-cycle pulse with `pkt_done`, parity mismatch.
- `pkt_abort` out 1: one-cycle pulse, packet killed by `soft_rst`.
- `pkt_count` out 16: number of good packets, wraps at 0xFFFF.

## Operation
- Packet format: header {len[5:0], addr[1:0]}, then len payload bytes (0..63), then a parity byte. Parity = XOR of the header and all payload bytes.
- IDLE: `vld_out` → WAIT with `dcnt`=0. If `START_DELAY`=0, go straight to HDR_RD.
- WAIT: `!vld_out` → IDLE. `dcnt`==`START_DELAY`-1 → HDR_RD. Otherwise `dcnt`++.
- HDR_RD: `read_enb` = `vld_out & !stall`. A cycle with `read_enb` high → HDR_WAIT.
- HDR_WAIT: `data_out` is the header.
  - Latch `pkt_len`/`pkt_addr`; parity accumulator = header; remaining = len+1.
  - Output the header with `pkt_sop`.
  - Go to BODY.
- BODY: `read_enb` = `vld_out & !stall & (issued < remaining)`.
  - Each returned byte (the cycle after its read) is output on `pkt_data`.
  - Payload bytes are XORed into the accumulator.
  - The final byte is the parity byte: output with `pkt_eop`, compare with the accumulator, → DONE.
- DONE, one cycle:
  - `pkt_done`=1.
  - `pkt_err`=1 if mismatch.
  - `pkt_count`++ if match.
  - → IDLE.
- `soft_rst` high in any state except IDLE:
  - `read_enb` forced 0 that cycle.
  - An outstanding returned byte is discarded.
  - At the next edge: `pkt_abort`=1, state IDLE, no `pkt_done`, `pkt_count` unchanged.
  - In IDLE, `soft_rst` is ignored.
- `vld_out` low during HDR_RD/BODY is a pause, not an error: no reads, state held.
- `stall` high: `read_enb` is held low. It does not suppress data already in flight; that byte is still delivered.

## Timing
- Reset: state IDLE; every output is 0, including `pkt_count` and the latched `pkt_len`/`pkt_addr`. Reset acts immediately and asynchronously.
- Read pipeline: `read_enb` in cycle t → `data_out` valid in t+1 → `pkt_data`/`pkt_data_vld` in t+2.
- Start latency: `vld_out` first sampled high at edge 0 → `read_enb` high in the cycle after edge `START_DELAY`.
  - That is `START_DELAY`+1 cycles, always below the 30-cycle soft-reset threshold.
- Throughput:
  - One bubble cycle (HDR_WAIT) after the header read.
  - Then len+1 back-to-back reads when unstalled.
  - Total reads per packet: len+2.
- `pkt_done`/`pkt_err` assert in the same cycle as the parity byte on `pkt_data` (with `pkt_eop`).
- `pkt_count` updates at that same edge.
- Earliest next header read: two cycles after DONE (IDLE → WAIT/HDR_RD).
- `pkt_sop`/`pkt_eop`/`pkt_data_vld` are single-cycle per byte. For len=0 the bytes are header then parity, in consecutive-capable cycles.

## Test plan
- Reset mid-BODY → all outputs 0 asynchronously, state IDLE; no `pkt_done` after release.
- `START_DELAY`=2, packet 0x0D, 0xAA, 0x55, 0x0F, 0xFD (len 3, addr 1), no stall:
  - first `read_enb` 3 cycles after `vld_out`;
  - 5 reads total;
  - `pkt_sop` on 0x0D, `pkt_eop` on 0xFD;
  - `pkt_done`=1, `pkt_err`=0, `pkt_count`=1, `pkt_len`=3, `pkt_addr`=1.
- Same packet with parity 0x00 → `pkt_done`=1, `pkt_err`=1, `pkt_count` unchanged.
- `stall` high for 4 cycles after the second payload read:
  - `read_enb` low for exactly those 4 cycles;
  - bytes in order, none lost or duplicated;
  - `pkt_err`=0.
- `vld_out` low for 3 cycles mid-BODY → reads pause and resume; packet completes good.
- `soft_rst` during BODY:
  - `pkt_abort` pulses once, no `pkt_done`, `pkt_count` unchanged;
  - the following packet 0x02, 0x02 (len 0, addr 2) then completes good with 2 reads.

Source files
------------

// File: rtl/router_out_reader.sv
// Drains one router output FIFO, re-frames each packet as a sop/eop-marked byte stream
// and checks the trailing XOR parity byte against the header and payload.
module router_out_reader #(
    parameter int unsigned START_DELAY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        vld_out,
    input  logic [7:0]  data_out,
    input  logic        soft_rst,
    input  logic        stall,
    output logic        read_enb,
    output logic [7:0]  pkt_data,
    output logic        pkt_data_vld,
    output logic        pkt_sop,
    output logic        pkt_eop,
    output logic [5:0]  pkt_len,
    output logic [1:0]  pkt_addr,
    output logic        pkt_done,
    output logic        pkt_err,
    output logic        pkt_abort,
    output logic [15:0] pkt_count
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT     = 3'd1;
    localparam logic [2:0] S_HDR_RD   = 3'd2;
    localparam logic [2:0] S_HDR_WAIT = 3'd3;
    localparam logic [2:0] S_BODY     = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam logic [4:0] DCNT_LAST = (START_DELAY == 0) ? 5'd0 : 5'(START_DELAY - 1);

    logic [2:0]  r_state;
    logic [4:0]  r_dcnt;
    logic [6:0]  r_remaining;
    logic [6:0]  r_issued;
    logic [6:0]  r_received;
    logic        r_inflight;
    logic [7:0]  r_acc;
    logic [7:0]  r_pkt_data;
    logic        r_data_vld;
    logic        r_sop;
    logic        r_eop;
    logic [5:0]  r_len;
    logic [1:0]  r_addr;
    logic        r_done;
    logic        r_err;
    logic        r_abort;
    logic [15:0] r_count;

    logic w_body_more;
    logic w_read_enb;
    logic w_last_byte;
    logic w_abort;

    assign w_body_more = (r_issued < r_remaining);
    assign w_last_byte = (r_received == (r_remaining - 7'd1));
    assign w_abort     = soft_rst && (r_state != S_IDLE);

    // soft_rst kills any read in the same cycle; the FIFO is being flushed under us
    assign w_read_enb = !soft_rst && vld_out && !stall &&
                        ((r_state == S_HDR_RD) || ((r_state == S_BODY) && w_body_more));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_dcnt      <= 5'd0;
            r_remaining <= 7'd0;
            r_issued    <= 7'd0;
            r_received  <= 7'd0;
            r_inflight  <= 1'b0;
            r_acc       <= 8'h00;
            r_pkt_data  <= 8'h00;
            r_data_vld  <= 1'b0;
            r_sop       <= 1'b0;
            r_eop       <= 1'b0;
            r_len       <= 6'd0;
            r_addr      <= 2'd0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_abort     <= 1'b0;
            r_count     <= 16'd0;
        end else begin
            r_data_vld <= 1'b0;
            r_sop      <= 1'b0;
            r_eop      <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_abort    <= 1'b0;
            if (w_abort) begin
                r_state    <= S_IDLE;
                r_abort    <= 1'b1;
                r_inflight <= 1'b0;
            end else begin
                // header read returns in HDR_WAIT, so only body reads are tracked here
                r_inflight <= w_read_enb && (r_state == S_BODY);
                case (r_state)
                    S_IDLE: begin
                        if (vld_out) begin
                            r_dcnt  <= 5'd0;
                            r_state <= (START_DELAY == 0) ? S_HDR_RD : S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (!vld_out) begin
                            r_state <= S_IDLE;
                        end else if (r_dcnt == DCNT_LAST) begin
                            r_state <= S_HDR_RD;
                        end else begin
                            r_dcnt <= r_dcnt + 5'd1;
                        end
                    end
                    S_HDR_RD: begin
                        if (w_read_enb) begin
                            r_state <= S_HDR_WAIT;
                        end
                    end
                    S_HDR_WAIT: begin
                        r_len       <= data_out[7:2];
                        r_addr      <= data_out[1:0];
                        r_acc       <= data_out;
                        r_remaining <= {1'b0, data_out[7:2]} + 7'd1;
                        r_issued    <= 7'd0;
                        r_received  <= 7'd0;
                        r_pkt_data  <= data_out;
                        r_data_vld  <= 1'b1;
                        r_sop       <= 1'b1;
                        r_state     <= S_BODY;
                    end
                    S_BODY: begin
                        if (w_read_enb) begin
                            r_issued <= r_issued + 7'd1;
                        end
                        if (r_inflight) begin
                            r_pkt_data <= data_out;
                            r_data_vld <= 1'b1;
                            r_received <= r_received + 7'd1;
                            if (w_last_byte) begin
                                r_eop   <= 1'b1;
                                r_done  <= 1'b1;
                                r_err   <= (r_acc != data_out);
                                r_state <= S_DONE;
                                if (r_acc == data_out) begin
                                    r_count <= r_count + 16'd1;
                                end
                            end else begin
                                r_acc <= r_acc ^ data_out;
                            end
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign read_enb     = w_read_enb;
    assign pkt_data     = r_pkt_data;
    assign pkt_data_vld = r_data_vld;
    assign pkt_sop      = r_sop;
    assign pkt_eop      = r_eop;
    assign pkt_len      = r_len;
    assign pkt_addr     = r_addr;
    assign pkt_done     = r_done;
    assign pkt_err      = r_err;
    assign pkt_abort    = r_abort;
    assign pkt_count    = r_count;

endmodule

// File: tb/tb_router_out_reader.sv
// Bench for router_out_reader: a queue-based FIFO feeds packets, and a packet-level model
// predicts the framed byte stream, parity verdicts, good-packet count and read timing.
module tb_router_out_reader;

    localparam int unsigned SD = 2;

    logic        clock;
    logic        reset;
    logic        vld_out;
    logic [7:0]  data_out;
    logic        soft_rst;
    logic        stall;
    logic        read_enb;
    logic [7:0]  pkt_data;
    logic        pkt_data_vld;
    logic        pkt_sop;
    logic        pkt_eop;
    logic [5:0]  pkt_len;
    logic [1:0]  pkt_addr;
    logic        pkt_done;
    logic        pkt_err;
    logic        pkt_abort;
    logic [15:0] pkt_count;

    router_out_reader #(.START_DELAY(SD)) u_dut (
        .clock        (clock),
        .reset        (reset),
        .vld_out      (vld_out),
        .data_out     (data_out),
        .soft_rst     (soft_rst),
        .stall        (stall),
        .read_enb     (read_enb),
        .pkt_data     (pkt_data),
        .pkt_data_vld (pkt_data_vld),
        .pkt_sop      (pkt_sop),
        .pkt_eop      (pkt_eop),
        .pkt_len      (pkt_len),
        .pkt_addr     (pkt_addr),
        .pkt_done     (pkt_done),
        .pkt_err      (pkt_err),
        .pkt_abort    (pkt_abort),
        .pkt_count    (pkt_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  fifo[$];
    logic [7:0]  pkt_bytes[$];
    logic [7:0]  exp_b[$];
    bit          exp_sop[$];
    bit          exp_eop[$];
    int          rec_len[$];
    int          rec_addr[$];
    bit          rec_err[$];
    logic [15:0] model_cnt;

    bit rd_req, hold_vld, stall_req, srst_req, rand_mode, done_seen, abort_seen, last_err;
    int cyc, reads, first_rd, vld_rise, n_done, n_abort;
    int stall_at, pause_at, srst_at, rst_at;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic flush_model();
        fifo.delete();
        exp_b.delete();
        exp_sop.delete();
        exp_eop.delete();
        rec_len.delete();
        rec_addr.delete();
        rec_err.delete();
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_rd"},    read_enb,     1'b0);
        check({tag, "_data"},  pkt_data,     8'h00);
        check({tag, "_vld"},   pkt_data_vld, 1'b0);
        check({tag, "_sop"},   pkt_sop,      1'b0);
        check({tag, "_eop"},   pkt_eop,      1'b0);
        check({tag, "_len"},   pkt_len,      6'd0);
        check({tag, "_addr"},  pkt_addr,     2'd0);
        check({tag, "_done"},  pkt_done,     1'b0);
        check({tag, "_err"},   pkt_err,      1'b0);
        check({tag, "_abort"}, pkt_abort,    1'b0);
        check({tag, "_count"}, pkt_count,    16'd0);
    endtask

    task automatic monitor();
        logic [7:0] eb;
        bit es, ee, er;
        int el, ea;
        rd_req = read_enb;
        if (read_enb) begin
            reads++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (pkt_data_vld) begin
            if (exp_b.size() == 0) begin
                check("spurious_vld", pkt_data_vld, 1'b0);
            end else begin
                eb = exp_b.pop_front();
                es = exp_sop.pop_front();
                ee = exp_eop.pop_front();
                check("data", pkt_data, eb);
                check("sop", pkt_sop, es);
                check("eop", pkt_eop, ee);
            end
        end else begin
            check("sop_idle", pkt_sop, 1'b0);
            check("eop_idle", pkt_eop, 1'b0);
        end
        if (pkt_done) begin
            done_seen = 1'b1;
            n_done++;
            last_err = pkt_err;
            if (rec_len.size() == 0) begin
                check("spurious_done", pkt_done, 1'b0);
            end else begin
                el = rec_len.pop_front();
                ea = rec_addr.pop_front();
                er = rec_err.pop_front();
                if (!er) model_cnt = model_cnt + 16'd1;
                check("err", pkt_err, er);
                check("len", pkt_len, el);
                check("addr", pkt_addr, ea);
            end
        end else begin
            check("err_idle", pkt_err, 1'b0);
        end
        if (pkt_abort) begin
            abort_seen = 1'b1;
            n_abort++;
        end
        check("count", pkt_count, model_cnt);
    endtask

    // One clock: FIFO pop for the read seen last cycle, apply inputs, then sample outputs.
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        if (rd_req) begin
            if (fifo.size() == 0) check("rd_when_empty", fifo.size(), 1);
            else data_out = fifo.pop_front();
            rd_req = 1'b0;
        end
        if (soft_rst) flush_model();
        soft_rst = srst_req;
        stall    = stall_req;
        vld_out  = (fifo.size() > 0) && !hold_vld;
        if (vld_out && vld_rise < 0) vld_rise = cyc;
        @(negedge clock);
        monitor();
    endtask

    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        chk_zero("midrst");
        flush_model();
        model_cnt = 16'd0;
        rd_req    = 1'b0;
        data_out  = 8'h00;
        vld_out   = 1'b0;
        stall     = 1'b0;
        soft_rst  = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    task automatic run_pkt();
        logic [7:0] hdr, x, par;
        int len, t, stall_left, pause_left;
        bit err, f_stall, f_pause, want_resume, stall_done, pause_done, srst_done, rst_hit;
        hdr = pkt_bytes[0];
        len = int'(hdr[7:2]);
        x = 8'h00;
        for (int i = 0; i <= len; i++) x = x ^ pkt_bytes[i];
        par = pkt_bytes[len + 1];
        err = (x != par);
        for (int i = 0; i < len + 2; i++) begin
            fifo.push_back(pkt_bytes[i]);
            exp_b.push_back(pkt_bytes[i]);
            exp_sop.push_back(i == 0);
            exp_eop.push_back(i == len + 1);
        end
        rec_len.push_back(len);
        rec_addr.push_back(int'(hdr[1:0]));
        rec_err.push_back(err);
        reads = 0; first_rd = -1; vld_rise = -1; done_seen = 1'b0; abort_seen = 1'b0;
        stall_left = 0; pause_left = 0; want_resume = 1'b0;
        stall_done = 1'b0; pause_done = 1'b0; srst_done = 1'b0; rst_hit = 1'b0;
        t = 0;
        while (!done_seen && !abort_seen && t < 600) begin
            if (rst_at != 0 && reads >= rst_at) begin
                async_reset();
                rst_hit = 1'b1;
                break;
            end
            if (stall_at != 0 && reads == stall_at && !stall_done) begin
                stall_left = 4; stall_done = 1'b1;
            end
            if (pause_at != 0 && reads == pause_at && !pause_done) begin
                pause_left = 3; pause_done = 1'b1;
            end
            f_stall = (stall_left > 0);
            f_pause = (pause_left > 0);
            if (f_stall) stall_left--;
            if (f_pause) pause_left--;
            stall_req = f_stall || (rand_mode && reads > 0 && $urandom_range(0, 3) == 0);
            hold_vld  = f_pause || (rand_mode && reads > 0 && $urandom_range(0, 4) == 0);
            srst_req  = (srst_at != 0 && reads == srst_at && !srst_done);
            if (srst_req) srst_done = 1'b1;
            step();
            t++;
            if (f_stall || f_pause || srst_req) check("held_rd", read_enb, 1'b0);
            else if (want_resume) check("resume_rd", read_enb, 1'b1);
            want_resume = (f_stall && stall_left == 0) || (f_pause && pause_left == 0);
        end
        if (!rst_hit) begin
            check("pkt_ends", done_seen | abort_seen, 1'b1);
            if (first_rd >= 0 && vld_rise >= 0) check("start_lat", first_rd - vld_rise, SD + 1);
            if (done_seen) check("reads", reads, len + 2);
        end
        stall_req = 1'b0;
        hold_vld  = 1'b0;
        srst_req  = 1'b0;
        step();
        step();
    endtask

    task automatic load_pkt1(input logic [7:0] parity);
        pkt_bytes = '{8'h0D, 8'hAA, 8'h55, 8'h0F, parity};
    endtask

    task automatic clear_knobs();
        stall_at = 0; pause_at = 0; srst_at = 0; rst_at = 0; rand_mode = 1'b0;
    endtask

    initial begin
        int d0, a0, len;
        logic [7:0] x, hdr;
        reset = 1'b1; vld_out = 1'b0; data_out = 8'h00; soft_rst = 1'b0; stall = 1'b0;
        rd_req = 1'b0; hold_vld = 1'b0; stall_req = 1'b0; srst_req = 1'b0; last_err = 1'b0;
        cyc = 0; reads = 0; first_rd = -1; vld_rise = -1; n_done = 0; n_abort = 0;
        model_cnt = 16'd0;
        clear_knobs();

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_zero("reset");
        reset = 1'b0;
        step();
        step();

        // good packet, len 3 addr 1
        load_pkt1(8'hFD);
        run_pkt();
        check("p1_lat", first_rd - vld_rise, 3);
        check("p1_reads", reads, 5);
        check("p1_err", last_err, 1'b0);
        check("p1_count", pkt_count, 16'd1);
        check("p1_len", pkt_len, 6'd3);
        check("p1_addr", pkt_addr, 2'd1);

        // bad parity
        load_pkt1(8'h00);
        run_pkt();
        check("p2_done", done_seen, 1'b1);
        check("p2_err", last_err, 1'b1);
        check("p2_count", pkt_count, 16'd1);

        // 4-cycle stall after the second payload read
        stall_at = 3;
        load_pkt1(8'hFD);
        run_pkt();
        check("p3_err", last_err, 1'b0);
        check("p3_count", pkt_count, 16'd2);
        clear_knobs();

        // vld_out low for 3 cycles mid-body
        pause_at = 3;
        load_pkt1(8'hFD);
        run_pkt();
        check("p4_err", last_err, 1'b0);
        check("p4_count", pkt_count, 16'd3);
        clear_knobs();

        // soft reset mid-body, then a len-0 packet
        d0 = n_done;
        a0 = n_abort;
        srst_at = 3;
        load_pkt1(8'hFD);
        run_pkt();
        step();
        check("abort_once", n_abort - a0, 1);
        check("abort_no_done", n_done - d0, 0);
        check("abort_count", pkt_count, 16'd3);
        clear_knobs();
        pkt_bytes = '{8'h02, 8'h02};
        run_pkt();
        check("p5_reads", reads, 2);
        check("p5_err", last_err, 1'b0);
        check("p5_count", pkt_count, 16'd4);
        check("p5_addr", pkt_addr, 2'd2);
        check("p5_len", pkt_len, 6'd0);

        // asynchronous reset mid-body
        d0 = n_done;
        rst_at = 3;
        load_pkt1(8'hFD);
        run_pkt();
        repeat (5) step();
        check("rst_no_done", n_done - d0, 0);
        check("rst_count", pkt_count, 16'd0);
        clear_knobs();

        // randomized packets with random stall/pause, bad parity and occasional soft reset
        rand_mode = 1'b1;
        for (int p = 0; p < 40; p++) begin
            len = ($urandom_range(0, 9) == 0) ? 63 : int'($urandom_range(0, 15));
            hdr = {len[5:0], 2'($urandom_range(0, 3))};
            pkt_bytes.delete();
            pkt_bytes.push_back(hdr);
            x = hdr;
            for (int i = 0; i < len; i++) begin
                pkt_bytes.push_back(8'($urandom));
                x = x ^ pkt_bytes[i + 1];
            end
            if ($urandom_range(0, 7) == 0) x = x ^ 8'(1 + $urandom_range(0, 254));
            pkt_bytes.push_back(x);
            srst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, len + 1)) : 0;
            run_pkt();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
